// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data memory between port 0 (core load/store) and
// port 1 (external loader/debug). Ties are broken round-robin. Port 1 may lock
// the bus across consecutive grants, but only for MAX_BURST grants while
// port 0 is waiting. Read data comes back registered, one cycle after the grant.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no ownership held; ties are decided by the last-granted port
// OWN1  | port 1 holds a lock; it keeps winning ties until cnt hits MAX_BURST
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    input  logic          lock1,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef enum logic {
        IDLE = 1'b0,
        OWN1 = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic          gnt0_c, gnt1_c;

    // Grant decision: a lone requester wins outright; ties go to the locked
    // owner until the burst limit forces a release, otherwise round-robin.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (req0 && req1) begin
            if (state_q == OWN1 && lock1) begin
                if (cnt_q < CNT_MAX) gnt1_c = 1'b1;
                else                 gnt0_c = 1'b1;
            end else if (last_q) begin
                gnt0_c = 1'b1;
            end else begin
                gnt1_c = 1'b1;
            end
        end else begin
            gnt0_c = req0;
            gnt1_c = req1;
        end
    end

    // Memory bus follows the granted port; idle bus is driven to zero.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (gnt0_c) begin
            mem_we   = we0;
            mem_addr = addr0;
            mem_wd   = wdata0;
        end else if (gnt1_c) begin
            mem_we   = we1;
            mem_addr = addr1;
            mem_wd   = wdata1;
        end
    end

    // Next ownership, last-granted port and starvation counter. The counter
    // only advances while port 1 keeps a locked grant with port 0 waiting;
    // any other cycle (gnt0, release to IDLE, req0 low) clears it.
    always_comb begin
        state_d = (gnt1_c && lock1) ? OWN1 : IDLE;
        last_d  = last_q;
        if (gnt0_c)      last_d = 1'b0;
        else if (gnt1_c) last_d = 1'b1;
        cnt_d = '0;
        if (gnt1_c && lock1 && req0)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end

    // All arbiter state and the registered read response.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= gnt0_c && !we0;
            rvalid1_q <= gnt1_c && !we1;
            if (gnt0_c && !we0) rdata0_q <= mem_rd;
            if (gnt1_c && !we1) rdata1_q <= mem_rd;
        end
    end

    assign gnt0    = gnt0_c;
    assign gnt1    = gnt1_c;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed table of grant patterns, hand-written
// reset and write/read sequences, then randomized traffic against a
// behavioural model of the arbitration rules and of the memory contents.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          areset;
    logic          req0, we0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .areset(areset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .lock1(lock1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Environment memory: 256 words, unwritten words read a fixed pattern.
    function automatic logic [DW-1:0] init_word(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    logic [DW-1:0] env_mem [256];
    bit            env_wr  [256];
    assign mem_rd = env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_word(mem_addr[7:0]);
    always @(posedge clk) begin
        if (mem_we) begin
            env_mem[mem_addr[7:0]] <= mem_wd;
            env_wr[mem_addr[7:0]]  <= 1'b1;
        end
    end

    // Checking
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // Reference model: arbitration history and memory contents
    int            m_last;
    bit            m_owned;
    int            m_burst;
    logic [DW-1:0] m_rd0, m_rd1;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    bit            prev_g0, prev_g1;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a[7:0]);
    endfunction

    function automatic void model_reset();
        m_last  = 1;
        m_owned = 1'b0;
        m_burst = 0;
        m_rd0   = '0;
        m_rd1   = '0;
        prev_g0 = 1'b0;
        prev_g1 = 1'b0;
    endfunction

    function automatic void model_grant(output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (req0 && !req1)      g0 = 1'b1;
        else if (req1 && !req0) g1 = 1'b1;
        else if (req0 && req1) begin
            if (m_owned && lock1) begin
                if (m_burst < MB) g1 = 1'b1;
                else              g0 = 1'b1;
            end else if (m_last == 1) g0 = 1'b1;
            else                      g1 = 1'b1;
        end
    endfunction

    // One clock cycle: inputs already driven. Checks combinational outputs at
    // the falling edge and registered outputs just after the rising edge.
    task automatic cycle(input string tag, input bit use_tab, input bit eg0, input bit eg1);
        bit            g0, g1, ew, nrv0, nrv1;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        model_grant(g0, g1);
        if (use_tab) begin
            chk({tag, " tab gnt0"}, 64'(gnt0), 64'(eg0));
            chk({tag, " tab gnt1"}, 64'(gnt1), 64'(eg1));
        end
        chk({tag, " gnt0"}, 64'(gnt0), 64'(g0));
        chk({tag, " gnt1"}, 64'(gnt1), 64'(g1));
        ew = g0 ? we0    : (g1 ? we1    : 1'b0);
        ea = g0 ? addr0  : (g1 ? addr1  : '0);
        ed = g0 ? wdata0 : (g1 ? wdata1 : '0);
        chk({tag, " mem_we"},   64'(mem_we),   64'(ew));
        chk({tag, " mem_addr"}, 64'(mem_addr), 64'(ea));
        chk({tag, " mem_wd"},   64'(mem_wd),   64'(ed));
        chk({tag, " cnt bound"}, 64'(dut.cnt_q <= 3'(MB)), 64'd1);
        nrv0 = g0 && !we0;
        nrv1 = g1 && !we1;
        if (nrv0) m_rd0 = ref_read(addr0);
        if (nrv1) m_rd1 = ref_read(addr1);
        if (g0 && we0) ref_mem[addr0] = wdata0;
        if (g1 && we1) ref_mem[addr1] = wdata1;
        m_burst = (g1 && lock1 && req0) ? ((m_burst + 1 > MB) ? MB : m_burst + 1) : 0;
        m_owned = g1 && lock1;
        if (g0)      m_last = 0;
        else if (g1) m_last = 1;
        prev_g0 = g0;
        prev_g1 = g1;
        @(posedge clk);
        #1;
        chk({tag, " rvalid0"}, 64'(rvalid0), 64'(nrv0));
        chk({tag, " rvalid1"}, 64'(rvalid1), 64'(nrv1));
        chk({tag, " rdata0"},  64'(rdata0),  64'(m_rd0));
        chk({tag, " rdata1"},  64'(rdata1),  64'(m_rd1));
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input bit l1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        lock1 = l1;
    endtask

    typedef struct {
        bit r0, w0, r1, w1, l1, eg0, eg1;
    } vec_t;

    vec_t tab[$];

    function automatic void add(input bit r0, input bit w0, input bit r1, input bit w1,
                                input bit l1, input bit eg0, input bit eg1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.l1 = l1; v.eg0 = eg0; v.eg1 = eg1;
        tab.push_back(v);
    endfunction

    initial begin
        // Round-robin from reset: port 0 wins the first tie, then alternates
        for (int i = 0; i < 4; i++) add(1, 0, 1, 0, 0, (i % 2) == 0, (i % 2) == 1);
        // Port 1 alone takes the lock
        add(0, 0, 1, 0, 1, 0, 1);
        // Port 0 waits: exactly MB locked grants, then forced release, then resume
        for (int i = 0; i < MB; i++) add(1, 0, 1, 0, 1, 0, 1);
        add(1, 0, 1, 0, 1, 1, 0);
        add(1, 0, 1, 0, 1, 0, 1);
        // Lock dropped on a tie: round-robin, last was port 1
        add(1, 0, 1, 0, 0, 1, 0);
        // Port 1 locks then drops req: port 0 served at once
        add(0, 0, 1, 1, 1, 0, 1);
        add(1, 0, 0, 0, 1, 1, 0);
        // Single requester for 8 cycles, mixed reads/writes
        for (int i = 0; i < 8; i++) add(1, i % 2, 0, 0, 0, 1, 0);
        // Idle bus
        add(0, 0, 0, 0, 0, 0, 0);

        model_reset();
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
        areset = 1'b0;
        #1;
        chk("reset rvalid0", 64'(rvalid0), 64'd0);
        chk("reset rdata1",  64'(rdata1),  64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset = 1'b1;
        @(posedge clk);
        #1;

        // Port 1 writes, port 0 reads it back one cycle after its grant
        drive(0, 0, '0, '0, 1, 1, 32'h10, 32'hDEADBEEF, 0);
        cycle("wr1", 0, 0, 0);
        drive(1, 0, 32'h10, '0, 0, 0, '0, '0, 0);
        cycle("rd0", 0, 0, 0);
        chk("wr_rd rvalid0", 64'(rvalid0), 64'd1);
        chk("wr_rd rdata0",  64'(rdata0),  64'h0000_0000_DEAD_BEEF);

        // Reset asserted while a granted read is pending: response dropped
        drive(1, 0, 32'h33, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        chk("midrd gnt0", 64'(gnt0), 64'd1);
        areset = 1'b0;
        #1;
        chk("midrd rvalid0", 64'(rvalid0), 64'd0);
        chk("midrd rdata0",  64'(rdata0),  64'd0);
        chk("midrd mem_we",  64'(mem_we),  64'd0);
        @(posedge clk);
        #1;
        chk("midrd dropped rvalid0", 64'(rvalid0), 64'd0);
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        areset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Directed table
        foreach (tab[i]) begin
            drive(tab[i].r0, tab[i].w0, AW'(8'h20 + 8'(i)), $urandom,
                  tab[i].r1, tab[i].w1, AW'(8'h60 + 8'(i)), $urandom, tab[i].l1);
            cycle($sformatf("tab%0d", i), 1, tab[i].eg0, tab[i].eg1);
        end

        // Randomized traffic; a request not yet granted is held unchanged
        for (int i = 0; i < 500; i++) begin
            if (!(req0 && !prev_g0)) begin
                req0   = ($urandom_range(0, 3) != 0);
                we0    = 1'($urandom_range(0, 1));
                addr0  = AW'($urandom_range(0, 255));
                wdata0 = $urandom;
            end
            if (!(req1 && !prev_g1)) begin
                req1   = ($urandom_range(0, 3) != 0);
                we1    = 1'($urandom_range(0, 1));
                addr1  = AW'($urandom_range(0, 255));
                wdata1 = $urandom;
            end
            lock1 = ($urandom_range(0, 9) < 7);
            cycle($sformatf("rnd%0d", i), 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
